// File: rtl/matrix_seq_pkg.sv
// matrix_seq_pkg: shared types and constants for the matrix op sequencer.
// Holds the FSM state enum, the NOP opcode, row geometry and the row type.
package matrix_seq_pkg;
    localparam int ROW_W    = 128;
    localparam int NUM_ROWS = 4;
    localparam logic [2:0] OP_NOP = 3'b000;
    typedef logic [ROW_W-1:0] row_t;
    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_RD_B, S_LATCH, S_EXEC, S_WAIT, S_WR, S_FIN, S_ERR
    } seq_state_t;
endpackage

// File: rtl/matrix_seq_watchdog.sv
// matrix_seq_watchdog: counts consecutive cycles the sequencer spends in WAIT.
// Ports: i_clk, i_rst_n (async active-low), i_run (sequencer is in WAIT),
//        o_expire (high on the TIMEOUT-th consecutive WAIT cycle).
module matrix_seq_watchdog #(
    parameter int TIMEOUT = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= i_run ? r_cnt + 1'b1 : '0;
    end
    // r_cnt counts WAIT cycles already completed, so TIMEOUT-1 marks the last allowed one
    assign o_expire = i_run && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: runs one ALU command over NUM_ROWS memory rows
// (read A row, read B row, execute, write result) with abort on ALU error.
// Optional build macro SEQ_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT cycles).
// Ports: i_clk/i_rst_n clock and async active-low reset; i_cmd_* / o_cmd_ready
//        command handshake; o_mem_rd_* / i_mem_rd_data memory read port (data
//        one cycle after enable); o_mem_wr_* memory write port; o_alu_* /
//        i_alu_* ALU drive and status; o_busy, o_cmd_done, o_cmd_error status.
module matrix_op_sequencer
    import matrix_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_src_a,
    input  logic [ADDR_W-1:0] i_cmd_src_b,
    input  logic [ADDR_W-1:0] i_cmd_dst,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [ROW_W-1:0]  i_mem_rd_data,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [ROW_W-1:0]  o_mem_wr_data,
    output logic [2:0]        o_alu_operation,
    output logic              o_alu_clear_all,
    output logic [ROW_W-1:0]  o_alu_row_a,
    output logic [ROW_W-1:0]  o_alu_row_b,
    input  logic              i_alu_done,
    input  logic              i_alu_error,
    input  logic [ROW_W-1:0]  i_alu_result,
    output logic              o_busy,
    output logic              o_cmd_done,
    output logic              o_cmd_error
);
    seq_state_t        r_state;
    logic [1:0]        r_row;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_src_a, r_src_b, r_dst;
    logic              r_cmd_ready, r_busy, r_cmd_done, r_cmd_error, r_alu_clear;
    logic              r_mem_rd_en, r_mem_wr_en;
    logic [ADDR_W-1:0] r_mem_rd_addr, r_mem_wr_addr;
    row_t              r_mem_wr_data, r_alu_row_a, r_alu_row_b;
    logic [2:0]        r_alu_op;
    logic [1:0]        w_row_nxt;
    logic              w_timeout;

    assign w_row_nxt = r_row + 2'd1;

`ifdef SEQ_TIMEOUT_EN
    matrix_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_run    (r_state == S_WAIT),
        .o_expire (w_timeout)
    );
`else
    // WAIT never expires in this build; the expression only keeps TIMEOUT referenced
    assign w_timeout = (TIMEOUT < 0);
`endif

    // Outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_op          <= '0;
            r_src_a       <= '0;
            r_src_b       <= '0;
            r_dst         <= '0;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_cmd_done    <= 1'b0;
            r_cmd_error   <= 1'b0;
            r_alu_clear   <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_alu_row_a   <= '0;
            r_alu_row_b   <= '0;
            r_alu_op      <= '0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_cmd_error <= 1'b0;
            r_alu_clear <= 1'b0;
            case (r_state)
                S_IDLE: if (i_cmd_valid) begin
                    r_op        <= i_cmd_op;
                    r_src_a     <= i_cmd_src_a;
                    r_src_b     <= i_cmd_src_b;
                    r_dst       <= i_cmd_dst;
                    r_row       <= '0;
                    r_cmd_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    if (i_cmd_op == OP_NOP) begin
                        r_state     <= S_ERR;
                        r_cmd_error <= 1'b1;
                        r_alu_clear <= 1'b1;
                    end else begin
                        r_state       <= S_RD_A;
                        r_mem_rd_en   <= 1'b1;
                        r_mem_rd_addr <= i_cmd_src_a;
                    end
                end
                S_RD_A: begin
                    r_state       <= S_RD_B;
                    r_mem_rd_en   <= 1'b1;
                    r_mem_rd_addr <= r_src_b + ADDR_W'(r_row);
                end
                S_RD_B: begin
                    r_state     <= S_LATCH;
                    r_alu_row_a <= i_mem_rd_data;
                end
                S_LATCH: begin
                    r_state     <= S_EXEC;
                    r_alu_row_b <= i_mem_rd_data;
                    r_alu_op    <= r_op;
                end
                S_EXEC: r_state <= S_WAIT;
                S_WAIT: begin
                    // error outranks done, so a failing row is never written
                    if (i_alu_error || w_timeout) begin
                        r_state     <= S_ERR;
                        r_alu_op    <= '0;
                        r_cmd_error <= 1'b1;
                        r_alu_clear <= 1'b1;
                    end else if (i_alu_done) begin
                        r_state       <= S_WR;
                        r_alu_op      <= '0;
                        r_mem_wr_en   <= 1'b1;
                        r_mem_wr_addr <= r_dst + ADDR_W'(r_row);
                        r_mem_wr_data <= i_alu_result;
                    end
                end
                S_WR: if (r_row == 2'(NUM_ROWS - 1)) begin
                    r_state     <= S_FIN;
                    r_cmd_done  <= 1'b1;
                    r_alu_clear <= 1'b1;
                end else begin
                    r_state       <= S_RD_A;
                    r_row         <= w_row_nxt;
                    r_mem_rd_en   <= 1'b1;
                    r_mem_rd_addr <= r_src_a + ADDR_W'(w_row_nxt);
                end
                S_FIN, S_ERR: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready     = r_cmd_ready;
    assign o_mem_rd_en     = r_mem_rd_en;
    assign o_mem_rd_addr   = r_mem_rd_addr;
    assign o_mem_wr_en     = r_mem_wr_en;
    assign o_mem_wr_addr   = r_mem_wr_addr;
    assign o_mem_wr_data   = r_mem_wr_data;
    assign o_alu_operation = r_alu_op;
    assign o_alu_clear_all = r_alu_clear;
    assign o_alu_row_a     = r_alu_row_a;
    assign o_alu_row_b     = r_alu_row_b;
    assign o_busy          = r_busy;
    assign o_cmd_done      = r_cmd_done;
    assign o_cmd_error     = r_cmd_error;
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb_matrix_op_sequencer: self-checking bench with memory and ALU models.
module tb_matrix_op_sequencer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = '0;
    logic [7:0]   cmd_sa = '0, cmd_sb = '0, cmd_d = '0;
    logic [127:0] rd_data = '0;
    logic         alu_done = 1'b0, alu_error = 1'b0;
    logic [127:0] alu_result = '0;
    logic         o_cmd_ready, o_mem_rd_en, o_mem_wr_en, o_alu_clear_all, o_busy, o_cmd_done, o_cmd_error;
    logic [7:0]   o_mem_rd_addr, o_mem_wr_addr;
    logic [127:0] o_mem_wr_data, o_alu_row_a, o_alu_row_b;
    logic [2:0]   o_alu_op;

    int total = 0, bad = 0;
    logic [127:0] mem [256];
    logic [7:0]   rd_q[$], wa_q[$];
    logic [127:0] wd_q[$];
    int done_cnt, err_cnt, clr_cnt, op_act, op_bad, busy_bad;
    int exec_seen = 0, alu_cnt = 0, alu_row = 0, alu_delay = 0, alu_err_row = -1;
    bit alu_both = 0, hit;
    logic [2:0] exp_op = '0;

    matrix_op_sequencer #(.ADDR_W(8), .TIMEOUT(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_src_a(cmd_sa), .i_cmd_src_b(cmd_sb), .i_cmd_dst(cmd_d),
        .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_addr(o_mem_rd_addr), .i_mem_rd_data(rd_data),
        .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_addr(o_mem_wr_addr), .o_mem_wr_data(o_mem_wr_data),
        .o_alu_operation(o_alu_op), .o_alu_clear_all(o_alu_clear_all),
        .o_alu_row_a(o_alu_row_a), .o_alu_row_b(o_alu_row_b),
        .i_alu_done(alu_done), .i_alu_error(alu_error), .i_alu_result(alu_result),
        .o_busy(o_busy), .o_cmd_done(o_cmd_done), .o_cmd_error(o_cmd_error)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] alu_fn(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        logic signed [31:0] x, y, z;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            x = a[32*c +: 32];
            y = b[32*c +: 32];
            case (op)
                3'd1: z = x + y;
                3'd2: z = x - y;
                3'd3: z = x * y;
                3'd4: z = x & y;
                3'd5: z = x | y;
                3'd6: z = x ^ y;
                default: z = (x > y) ? x : y;
            endcase
            r[32*c +: 32] = z;
        end
        return r;
    endfunction

    // external memory: read data one cycle after enable
    always @(posedge clk) begin
        if (o_mem_rd_en) rd_data <= mem[o_mem_rd_addr];
        if (o_mem_wr_en) mem[o_mem_wr_addr] = o_mem_wr_data;
    end

    // ALU: responds alu_delay WAIT cycles after the first one; error on row alu_err_row
    always @(negedge clk) begin
        if (o_alu_op != 3'b000) begin
            alu_cnt++;
            if (alu_cnt == 1) begin
                alu_row = exec_seen;
                exec_seen++;
            end
            if (o_alu_op !== exp_op) op_bad++;
            hit = (alu_cnt == alu_delay + 2);
            alu_error = hit && (alu_row == alu_err_row);
            alu_done = hit && (!alu_error || alu_both);
            alu_result = hit ? alu_fn(o_alu_op, o_alu_row_a, o_alu_row_b) : '0;
        end else begin
            alu_cnt = 0;
            alu_done = 0;
            alu_error = 0;
            alu_result = '0;
        end
    end

    always @(negedge clk) begin
        if (o_mem_rd_en) rd_q.push_back(o_mem_rd_addr);
        if (o_mem_wr_en) begin
            wa_q.push_back(o_mem_wr_addr);
            wd_q.push_back(o_mem_wr_data);
        end
        if (o_cmd_done) done_cnt++;
        if (o_cmd_error) err_cnt++;
        if (o_alu_clear_all) clr_cnt++;
        if (o_alu_op != 3'b000) op_act++;
    end

    task automatic clear_logs;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        done_cnt = 0; err_cnt = 0; clr_cnt = 0; op_act = 0; op_bad = 0; busy_bad = 0; exec_seen = 0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] d,
                           input int dly, input int erow, input bit both, input int budget, output int lat);
        clear_logs();
        alu_delay = dly; alu_err_row = erow; alu_both = both; exp_op = op;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_sa = sa; cmd_sb = sb; cmd_d = d;
        @(posedge clk);
        #1 cmd_valid = 0;
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (!o_busy) busy_bad++;
            if (o_cmd_done || o_cmd_error) begin
                lat = n;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic predict(input logic [2:0] op, input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] d,
                           output logic [127:0] ed [4]);
        logic [127:0] m [256];
        for (int i = 0; i < 256; i++) m[i] = mem[i];
        for (int r = 0; r < 4; r++) begin
            ed[r] = alu_fn(op, m[8'(sa + r)], m[8'(sb + r)]);
            m[8'(d + r)] = ed[r];
        end
    endtask

    task automatic test_reset;
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_cmd_ready); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++;
        if ({o_mem_rd_en, o_mem_wr_en, o_cmd_done, o_cmd_error, o_alu_clear_all, o_alu_op} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {o_mem_rd_en, o_mem_wr_en, o_cmd_done, o_cmd_error, o_alu_clear_all, o_alu_op});
        end
        total++;
        if ({o_alu_row_a, o_alu_row_b, o_mem_wr_data, o_mem_rd_addr, o_mem_wr_addr} !== '0) begin
            bad++; $display("FAIL reset_data got nonzero exp=0");
        end
    endtask

    task automatic test_directed;
        int lat;
        logic [127:0] exp_d;
        for (int r = 0; r < 4; r++) begin
            mem[8'h10 + r] = {4{32'd4}};
            mem[8'h18 + r] = (r % 2 == 0) ? {4{32'hFFFF_FFFB}} : {4{32'd5}};
        end
        run_cmd(3'b001, 8'h10, 8'h18, 8'h50, 2, -1, 0, 100, lat);
        total++; if (lat != 33) begin bad++; $display("FAIL dir_latency got=%0d exp=33", lat); end
        total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL dir_pulses done=%0d err=%0d exp 1/0", done_cnt, err_cnt); end
        total++; if (clr_cnt != 1) begin bad++; $display("FAIL dir_clear got=%0d exp=1", clr_cnt); end
        total++; if (busy_bad != 0 || op_bad != 0) begin bad++; $display("FAIL dir_busy_op busy_bad=%0d op_bad=%0d exp 0", busy_bad, op_bad); end
        total++; if (wa_q.size() != 4) begin bad++; $display("FAIL dir_wr_count got=%0d exp=4", wa_q.size()); end
        for (int r = 0; r < 4 && r < wa_q.size(); r++) begin
            exp_d = (r % 2 == 0) ? {4{32'hFFFF_FFFF}} : {4{32'd9}};
            total++; if (wa_q[r] !== 8'(8'h50 + r)) begin bad++; $display("FAIL dir_wr_addr%0d got=%h exp=%h", r, wa_q[r], 8'(8'h50 + r)); end
            total++; if (wd_q[r] !== exp_d) begin bad++; $display("FAIL dir_wr_data%0d got=%h exp=%h", r, wd_q[r], exp_d); end
        end
        total++; if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL dir_idle ready=%b busy=%b exp 1/0", o_cmd_ready, o_busy); end
    endtask

    task automatic test_error_row2;
        int lat;
        logic [127:0] keep;
        keep = mem[8'h42];
        run_cmd(3'b010, 8'h20, 8'h30, 8'h40, 1, 2, 1, 100, lat);
        total++; if (lat != 21) begin bad++; $display("FAIL err_latency got=%0d exp=21", lat); end
        total++; if (wa_q.size() != 2) begin bad++; $display("FAIL err_wr_count got=%0d exp=2", wa_q.size()); end
        total++; if (err_cnt != 1 || done_cnt != 0) begin bad++; $display("FAIL err_pulses err=%0d done=%0d exp 1/0", err_cnt, done_cnt); end
        total++; if (clr_cnt != 1) begin bad++; $display("FAIL err_clear got=%0d exp=1", clr_cnt); end
        total++; if (mem[8'h42] !== keep) begin bad++; $display("FAIL err_row2_kept got=%h exp=%h", mem[8'h42], keep); end
    endtask

    task automatic test_nop;
        int lat;
        run_cmd(3'b000, 8'h01, 8'h02, 8'h03, 0, -1, 0, 20, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL nop_latency got=%0d exp=1", lat); end
        total++; if (rd_q.size() != 0 || wa_q.size() != 0) begin bad++; $display("FAIL nop_mem rd=%0d wr=%0d exp 0/0", rd_q.size(), wa_q.size()); end
        total++; if (op_act != 0 || err_cnt != 1 || done_cnt != 0) begin bad++; $display("FAIL nop_alu op_act=%0d err=%0d done=%0d exp 0/1/0", op_act, err_cnt, done_cnt); end
    endtask

    task automatic test_random(input int num, input bit wrap);
        int lat, dly;
        logic [2:0] op;
        logic [7:0] sa, sb, d;
        logic [127:0] ed [4];
        for (int k = 0; k < num; k++) begin
            op = 3'($urandom_range(1, 7));
            sa = wrap ? 8'hFE : 8'($urandom);
            sb = wrap ? 8'h10 : 8'($urandom);
            d  = wrap ? 8'hFF : 8'($urandom);
            dly = $urandom_range(0, 4);
            predict(op, sa, sb, d, ed);
            run_cmd(op, sa, sb, d, dly, -1, 0, 200, lat);
            total++; if (lat != 4 * (6 + dly) + 1) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, lat, 4 * (6 + dly) + 1); end
            total++; if (done_cnt != 1 || err_cnt != 0 || op_bad != 0) begin bad++; $display("FAIL rnd%0d_status done=%0d err=%0d op_bad=%0d exp 1/0/0", k, done_cnt, err_cnt, op_bad); end
            total++; if (rd_q.size() != 8 || wa_q.size() != 4) begin bad++; $display("FAIL rnd%0d_counts rd=%0d wr=%0d exp 8/4", k, rd_q.size(), wa_q.size()); end
            for (int r = 0; r < 4 && rd_q.size() == 8 && wa_q.size() == 4; r++) begin
                total++; if (rd_q[2*r] !== 8'(sa + r) || rd_q[2*r+1] !== 8'(sb + r)) begin
                    bad++; $display("FAIL rnd%0d_rd_addr%0d got=%h,%h exp=%h,%h", k, r, rd_q[2*r], rd_q[2*r+1], 8'(sa + r), 8'(sb + r)); end
                total++; if (wa_q[r] !== 8'(d + r)) begin bad++; $display("FAIL rnd%0d_wr_addr%0d got=%h exp=%h", k, r, wa_q[r], 8'(d + r)); end
                total++; if (wd_q[r] !== ed[r]) begin bad++; $display("FAIL rnd%0d_wr_data%0d got=%h exp=%h", k, r, wd_q[r], ed[r]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        clear_logs();
        alu_delay = 50; alu_err_row = -1; alu_both = 0; exp_op = 3'b011;
        @(negedge clk);
        cmd_valid = 1; cmd_op = 3'b011; cmd_sa = 8'h60; cmd_sb = 8'h70; cmd_d = 8'h80;
        @(posedge clk);
        #1 cmd_valid = 0;
        n = 0;
        while (!(exec_seen == 2 && o_alu_op != 3'b000) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (n >= 100) begin bad++; $display("FAIL rstmid_reach_row1 got=timeout exp=row1 wait"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        total++; if (o_busy !== 1'b0 || o_alu_op !== 3'b000) begin bad++; $display("FAIL rstmid_zero busy=%b op=%b exp 0/0", o_busy, o_alu_op); end
        total++; if ({o_mem_rd_en, o_mem_wr_en, o_cmd_done, o_cmd_error, o_alu_clear_all, o_alu_row_a, o_alu_row_b, o_mem_wr_data} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got nonzero exp=0"); end
        @(negedge clk);
        rst_n = 1;
        #1;
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", o_cmd_ready); end
        repeat (10) @(negedge clk);
        total++; if (done_cnt != 0 || err_cnt != 0) begin bad++; $display("FAIL rstmid_pulses done=%0d err=%0d exp 0/0", done_cnt, err_cnt); end
    endtask

    task automatic test_timeout;
        int lat;
`ifdef SEQ_TIMEOUT_EN
        run_cmd(3'b001, 8'h90, 8'hA0, 8'hB0, 1000, -1, 0, 200, lat);
        total++; if (lat != 37) begin bad++; $display("FAIL to_latency got=%0d exp=37", lat); end
        total++; if (err_cnt != 1 || done_cnt != 0 || wa_q.size() != 0) begin bad++; $display("FAIL to_status err=%0d done=%0d wr=%0d exp 1/0/0", err_cnt, done_cnt, wa_q.size()); end
`else
        run_cmd(3'b001, 8'h90, 8'hA0, 8'hB0, 1000, -1, 0, 100, lat);
        total++; if (lat != -1) begin bad++; $display("FAIL nto_hold got=%0d exp=no end", lat); end
        total++; if (o_busy !== 1'b1 || err_cnt != 0 || busy_bad != 0) begin bad++; $display("FAIL nto_busy busy=%b err=%0d exp 1/0", o_busy, err_cnt); end
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL nto_recover got=%b exp=1", o_cmd_ready); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        test_reset();
        test_directed();
        test_error_row2();
        test_nop();
        test_random(1, 1);
        test_random(20, 0);
        test_reset_mid();
        test_random(3, 0);
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=stuck exp=finish");
        $fatal(1);
    end
endmodule
